// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC register, next-PC select and IF/ID pipeline register.
// Stops fetching on HLT; only rst leaves the halted state.
module fetch_pc_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        update_PC,
    input  logic [15:0] actual_target,
    input  logic [15:0] instr,
    input  logic [1:0]  prediction,
    input  logic [15:0] predicted_target,
    output logic [15:0] PC_curr,
    output logic        pred_enable,
    output logic [15:0] IF_ID_PC_curr,
    output logic [15:0] IF_ID_PC_next,
    output logic [15:0] IF_ID_instr,
    output logic [1:0]  IF_ID_prediction,
    output logic [15:0] IF_ID_predicted_target,
    output logic        IF_ID_valid,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [15:0] pc_d;
    logic [15:0] pc_plus2;
    logic [15:0] if_pc_d;
    logic [15:0] if_next_d;
    logic [15:0] if_instr_d;
    logic [1:0]  if_pred_d;
    logic [15:0] if_ptgt_d;
    logic        if_valid_d;
    logic [15:0] cnt_d;

    logic is_hlt;
    logic sel_hold;
    logic sel_redir;
    logic sel_halt;
    logic sel_taken;
    logic sel_seq;
    logic do_bubble;
    logic do_latch;

    assign pc_plus2 = PC_curr + 16'd2;
    assign is_hlt   = (instr[15:12] == HLT_OPCODE);

    // Mutually exclusive selects encode the stall > redirect > HLT > taken
    // > sequential priority, so the decoder below can be unique.
    assign sel_hold  = stall;
    assign sel_redir = ~stall & update_PC;
    assign sel_halt  = ~stall & ~update_PC & is_hlt;
    assign sel_taken = ~stall & ~update_PC & ~is_hlt & prediction[1];
    assign sel_seq   = ~stall & ~update_PC & ~is_hlt & ~prediction[1];

    assign halted      = (state_q == HALTED);
    assign pred_enable = ~stall & ~halted;

    // Next-state, next-PC and IF/ID load decision.
    always_comb begin
        state_d    = state_q;
        pc_d       = PC_curr;
        do_bubble  = 1'b0;
        do_latch   = 1'b0;
        if_pc_d    = IF_ID_PC_curr;
        if_next_d  = IF_ID_PC_next;
        if_instr_d = IF_ID_instr;
        if_pred_d  = IF_ID_prediction;
        if_ptgt_d  = IF_ID_predicted_target;
        if_valid_d = IF_ID_valid;
        cnt_d      = fetch_count;
        unique case (state_q)
            RUN: begin
                unique case (1'b1)
                    sel_hold: ;
                    sel_redir: begin
                        pc_d      = {actual_target[15:1], 1'b0};
                        do_bubble = 1'b1;
                    end
                    sel_halt: begin
                        do_latch = 1'b1;
                        state_d  = HALTED;
                    end
                    sel_taken: begin
                        do_latch = 1'b1;
                        pc_d     = {predicted_target[15:1], 1'b0};
                    end
                    sel_seq: begin
                        do_latch = 1'b1;
                        pc_d     = pc_plus2;
                    end
                    default: ;
                endcase
            end
            HALTED: begin
                do_bubble = ~stall;
            end
            default: ;
        endcase
        if (do_bubble) begin
            if_pc_d    = 16'h0000;
            if_next_d  = 16'h0000;
            if_instr_d = 16'h0000;
            if_pred_d  = 2'b00;
            if_ptgt_d  = 16'h0000;
            if_valid_d = 1'b0;
        end
        if (do_latch) begin
            if_pc_d    = PC_curr;
            if_next_d  = pc_plus2;
            if_instr_d = instr;
            if_pred_d  = prediction;
            if_ptgt_d  = predicted_target;
            if_valid_d = 1'b1;
            cnt_d      = fetch_count + 16'd1;
        end
    end

    // State, PC, IF/ID and fetch counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q                <= RUN;
            PC_curr                <= RESET_PC;
            IF_ID_PC_curr          <= 16'h0000;
            IF_ID_PC_next          <= 16'h0000;
            IF_ID_instr            <= 16'h0000;
            IF_ID_prediction       <= 2'b00;
            IF_ID_predicted_target <= 16'h0000;
            IF_ID_valid            <= 1'b0;
            fetch_count            <= 16'h0000;
        end else begin
            state_q                <= state_d;
            PC_curr                <= pc_d;
            IF_ID_PC_curr          <= if_pc_d;
            IF_ID_PC_next          <= if_next_d;
            IF_ID_instr            <= if_instr_d;
            IF_ID_prediction       <= if_pred_d;
            IF_ID_predicted_target <= if_ptgt_d;
            IF_ID_valid            <= if_valid_d;
            fetch_count            <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed vector bench for fetch_pc_unit.
// Each record: inputs for one cycle, expected outputs after the edge.
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        update_PC;
    logic [15:0] actual_target;
    logic [15:0] instr;
    logic [1:0]  prediction;
    logic [15:0] predicted_target;
    logic [15:0] PC_curr;
    logic        pred_enable;
    logic [15:0] IF_ID_PC_curr;
    logic [15:0] IF_ID_PC_next;
    logic [15:0] IF_ID_instr;
    logic [1:0]  IF_ID_prediction;
    logic [15:0] IF_ID_predicted_target;
    logic        IF_ID_valid;
    logic        halted;
    logic [15:0] fetch_count;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_pc_unit dut (
        .clk                    (clk),
        .rst                    (rst),
        .stall                  (stall),
        .update_PC              (update_PC),
        .actual_target          (actual_target),
        .instr                  (instr),
        .prediction             (prediction),
        .predicted_target       (predicted_target),
        .PC_curr                (PC_curr),
        .pred_enable            (pred_enable),
        .IF_ID_PC_curr          (IF_ID_PC_curr),
        .IF_ID_PC_next          (IF_ID_PC_next),
        .IF_ID_instr            (IF_ID_instr),
        .IF_ID_prediction       (IF_ID_prediction),
        .IF_ID_predicted_target (IF_ID_predicted_target),
        .IF_ID_valid            (IF_ID_valid),
        .halted                 (halted),
        .fetch_count            (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        stall;
        logic        upd;
        logic [15:0] tgt;
        logic [15:0] instr;
        logic [1:0]  pred;
        logic [15:0] ptgt;
        logic        e_pe;
        logic [15:0] e_pc;
        logic        e_vld;
        logic [15:0] e_ifpc;
        logic [15:0] e_ifinstr;
        logic [1:0]  e_ifpred;
        logic [15:0] e_ifptgt;
        logic        e_halt;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input string       name,
        input logic        r,
        input logic        s,
        input logic        u,
        input logic [15:0] t,
        input logic [15:0] i,
        input logic [1:0]  p,
        input logic [15:0] pt,
        input logic        pe,
        input logic [15:0] pc,
        input logic        vld,
        input logic [15:0] ifpc,
        input logic [15:0] ifi,
        input logic [1:0]  ifp,
        input logic [15:0] ifpt,
        input logic        h,
        input logic [15:0] c
    );
        vec_t v;
        v.name = name; v.rst = r; v.stall = s; v.upd = u;
        v.tgt = t; v.instr = i; v.pred = p; v.ptgt = pt;
        v.e_pe = pe; v.e_pc = pc; v.e_vld = vld;
        v.e_ifpc = ifpc; v.e_ifinstr = ifi; v.e_ifpred = ifp;
        v.e_ifptgt = ifpt; v.e_halt = h; v.e_cnt = c;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst              = v.rst;
        stall            = v.stall;
        update_PC        = v.upd;
        actual_target    = v.tgt;
        instr            = v.instr;
        prediction       = v.pred;
        predicted_target = v.ptgt;
    endtask

    initial begin
        logic [15:0] e_next;

        // name rst stall upd tgt instr pred ptgt | pe pc vld ifpc ifinstr ifpred ifptgt halt cnt
        vecs.push_back(mk("seq0", 0,0,0,16'h0,16'h1234,2'b00,16'h0,
                          1,16'h0002,1,16'h0000,16'h1234,2'b00,16'h0,0,16'd1));
        vecs.push_back(mk("seq1", 0,0,0,16'h0,16'h1234,2'b00,16'h0,
                          1,16'h0004,1,16'h0002,16'h1234,2'b00,16'h0,0,16'd2));
        vecs.push_back(mk("taken", 0,0,0,16'h0,16'h1234,2'b10,16'h0041,
                          1,16'h0040,1,16'h0004,16'h1234,2'b10,16'h0041,0,16'd3));
        vecs.push_back(mk("weak_nt", 0,0,0,16'h0,16'h2222,2'b01,16'h0BAD,
                          1,16'h0042,1,16'h0040,16'h2222,2'b01,16'h0BAD,0,16'd4));
        vecs.push_back(mk("redir_odd", 0,0,1,16'h0011,16'h2222,2'b10,16'h0BAD,
                          1,16'h0010,0,16'h0000,16'h0000,2'b00,16'h0,0,16'd4));
        vecs.push_back(mk("redir_hlt", 0,0,1,16'h0100,16'hF000,2'b10,16'h0BAD,
                          1,16'h0100,0,16'h0000,16'h0000,2'b00,16'h0,0,16'd4));
        vecs.push_back(mk("after_redir", 0,0,0,16'h0,16'h3333,2'b00,16'h0,
                          1,16'h0102,1,16'h0100,16'h3333,2'b00,16'h0,0,16'd5));
        vecs.push_back(mk("stall_redir", 0,1,1,16'h0200,16'h4444,2'b10,16'h0060,
                          0,16'h0102,1,16'h0100,16'h3333,2'b00,16'h0,0,16'd5));
        vecs.push_back(mk("stall_hlt", 0,1,0,16'h0,16'hF000,2'b00,16'h0,
                          0,16'h0102,1,16'h0100,16'h3333,2'b00,16'h0,0,16'd5));
        vecs.push_back(mk("taken_odd", 0,0,0,16'h0,16'h5555,2'b11,16'hFFFF,
                          1,16'hFFFE,1,16'h0102,16'h5555,2'b11,16'hFFFF,0,16'd6));
        vecs.push_back(mk("wrap", 0,0,0,16'h0,16'h6666,2'b00,16'h0,
                          1,16'h0000,1,16'hFFFE,16'h6666,2'b00,16'h0,0,16'd7));
        vecs.push_back(mk("to_000A", 0,0,0,16'h0,16'h7777,2'b10,16'h000A,
                          1,16'h000A,1,16'h0000,16'h7777,2'b10,16'h000A,0,16'd8));
        vecs.push_back(mk("hlt", 0,0,0,16'h0,16'hF000,2'b00,16'h0,
                          1,16'h000A,1,16'h000A,16'hF000,2'b00,16'h0,1,16'd9));
        vecs.push_back(mk("halt_stall", 0,1,0,16'h0,16'h1111,2'b00,16'h0,
                          0,16'h000A,1,16'h000A,16'hF000,2'b00,16'h0,1,16'd9));
        vecs.push_back(mk("halt_redir", 0,0,1,16'h0300,16'hF000,2'b00,16'h0,
                          0,16'h000A,0,16'h0000,16'h0000,2'b00,16'h0,1,16'd9));
        vecs.push_back(mk("halt_taken", 0,0,0,16'h0,16'h1111,2'b10,16'h0080,
                          0,16'h000A,0,16'h0000,16'h0000,2'b00,16'h0,1,16'd9));
        vecs.push_back(mk("rst_exit", 1,0,0,16'h0,16'h1111,2'b10,16'h0080,
                          0,16'h0000,0,16'h0000,16'h0000,2'b00,16'h0,0,16'd0));
        vecs.push_back(mk("post_rst", 0,0,0,16'h0,16'h1234,2'b00,16'h0,
                          1,16'h0002,1,16'h0000,16'h1234,2'b00,16'h0,0,16'd1));

        // Reset from power-up, then check the reset state.
        rst = 1'b1; stall = 1'b0; update_PC = 1'b0;
        actual_target = 16'h0; instr = 16'h0;
        prediction = 2'b00; predicted_target = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", {16'h0, PC_curr}, {16'h0, 16'h0000});
        check("rst_vld", {31'h0, IF_ID_valid}, 32'h0);
        check("rst_pred", {30'h0, IF_ID_prediction}, 32'h0);
        check("rst_instr", {16'h0, IF_ID_instr}, 32'h0);
        check("rst_next", {16'h0, IF_ID_PC_next}, 32'h0);
        check("rst_halt", {31'h0, halted}, 32'h0);
        check("rst_cnt", {16'h0, fetch_count}, 32'h0);
        check("rst_pe", {31'h0, pred_enable}, 32'h1);

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k]);
            #1;
            check({vecs[k].name, ".pe"}, {31'h0, pred_enable},
                  {31'h0, vecs[k].e_pe});
            @(posedge clk);
            #1;
            e_next = vecs[k].e_vld ? vecs[k].e_ifpc + 16'd2 : 16'h0000;
            check({vecs[k].name, ".pc"}, {16'h0, PC_curr},
                  {16'h0, vecs[k].e_pc});
            check({vecs[k].name, ".vld"}, {31'h0, IF_ID_valid},
                  {31'h0, vecs[k].e_vld});
            check({vecs[k].name, ".ifpc"}, {16'h0, IF_ID_PC_curr},
                  {16'h0, vecs[k].e_ifpc});
            check({vecs[k].name, ".ifnext"}, {16'h0, IF_ID_PC_next},
                  {16'h0, e_next});
            check({vecs[k].name, ".ifinstr"}, {16'h0, IF_ID_instr},
                  {16'h0, vecs[k].e_ifinstr});
            check({vecs[k].name, ".ifpred"}, {30'h0, IF_ID_prediction},
                  {30'h0, vecs[k].e_ifpred});
            check({vecs[k].name, ".ifptgt"},
                  {16'h0, IF_ID_predicted_target},
                  {16'h0, vecs[k].e_ifptgt});
            check({vecs[k].name, ".halt"}, {31'h0, halted},
                  {31'h0, vecs[k].e_halt});
            check({vecs[k].name, ".cnt"}, {16'h0, fetch_count},
                  {16'h0, vecs[k].e_cnt});
        end

        // Multi-cycle: a long stall holds everything, then fetch resumes.
        @(negedge clk);
        stall = 1'b1; update_PC = 1'b1; actual_target = 16'h0400;
        instr = 16'h9999; prediction = 2'b10; predicted_target = 16'h0500;
        repeat (3) @(posedge clk);
        #1;
        check("lstall.pc", {16'h0, PC_curr}, 32'h0002);
        check("lstall.ifpc", {16'h0, IF_ID_PC_curr}, 32'h0000);
        check("lstall.cnt", {16'h0, fetch_count}, 32'h0001);
        @(negedge clk);
        stall = 1'b0;
        @(posedge clk);
        #1;
        check("lresume.pc", {16'h0, PC_curr}, 32'h0400);
        check("lresume.vld", {31'h0, IF_ID_valid}, 32'h0);
        @(negedge clk);
        update_PC = 1'b0;
        @(posedge clk);
        #1;
        check("lresume2.pc", {16'h0, PC_curr}, 32'h0500);
        check("lresume2.ifpc", {16'h0, IF_ID_PC_curr}, 32'h0400);
        check("lresume2.instr", {16'h0, IF_ID_instr}, 32'h9999);
        check("lresume2.cnt", {16'h0, fetch_count}, 32'h0002);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
